// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the PSRAM bus arbiter: frame/vblank timing,
// turnaround and release-timeout limits, and the ownership FSM state enum.
package psram_arb_pkg;

  localparam int V_ACTIVE      = 272;
  localparam int VBLANK_CYCLES = 12000;
  localparam int MIN_WINDOW    = 1024;
  localparam int REVOKE_MARGIN = 256;
  localparam int TURN_CYCLES   = 4;
  localparam int REL_TIMEOUT   = 64;

  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam int REM_W  = $clog2(VBLANK_CYCLES);
  localparam int CNT_W  = $clog2(((TURN_CYCLES > REL_TIMEOUT) ? TURN_CYCLES : REL_TIMEOUT) + 1);

  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);
  localparam logic [REM_W-1:0]  REM_LOAD  = REM_W'(VBLANK_CYCLES - 1);
  localparam logic [REM_W-1:0]  MIN_WIN_R = REM_W'(MIN_WINDOW);
  localparam logic [REM_W-1:0]  REVOKE_R  = REM_W'(REVOKE_MARGIN);
  localparam logic [CNT_W-1:0]  TURN_LAST = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(REL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    LCD_OWN       = 3'd0,
    REL_WAIT      = 3'd1,
    REL_GUARD     = 3'd2,
    MCU_OWN       = 3'd3,
    RECLAIM_WAIT  = 3'd4,
    RECLAIM_GUARD = 3'd5
  } arb_state_e;

endpackage

// File: rtl/psram_bus_arbiter_sync_2ff.sv
// Two-flop synchronizer, reset to 0, for bringing a level signal into the
// LCD pixel clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;
  logic meta_d;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/psram_bus_arbiter.sv
// Hands the shared QSPI PSRAM bus to the MCU only inside vertical blanking,
// with turnaround guards on both sides, and takes it back before the next frame.
module psram_bus_arbiter
  import psram_arb_pkg::*;
(
  input  logic       LCD_PCLK,
  input  logic       GLOBAL_RESET,
  input  logic       mcu_req,
  input  logic       lcd_vsync,
  input  logic       lcd_den,
  input  logic       psram_busy,
  output logic       psram_ctrl,
  output logic       mcu_ack,
  output logic       lcd_hold,
  output logic       frame_overrun,
  output logic [7:0] grant_cnt
);

  logic req_s;

  sync_2ff u_req_sync (
    .clk (LCD_PCLK),
    .rst (GLOBAL_RESET),
    .d   (mcu_req),
    .q   (req_s)
  );

  arb_state_e        state_q, state_d;
  logic              vsync_q, vsync_d;
  logic              den_q, den_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              in_vblank_q, in_vblank_d;
  logic [REM_W-1:0]  remain_q, remain_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic              ovr_flag_q, ovr_flag_d;
  logic              ovr_pulse_q, ovr_pulse_d;
  logic [7:0]        gcnt_q, gcnt_d;
  logic              ctrl_q, ctrl_d;
  logic              ack_q, ack_d;
  logic              hold_q, hold_d;
  logic              vsync_rise;
  logic              den_fall;

  // Frame tracking: count active lines, then run the vblank countdown.
  always_comb begin
    vsync_d     = lcd_vsync;
    den_d       = lcd_den;
    vsync_rise  = lcd_vsync & ~vsync_q;
    den_fall    = den_q & ~lcd_den;
    line_d      = line_q;
    in_vblank_d = in_vblank_q;
    remain_d    = remain_q;
    if (remain_q != '0) remain_d = remain_q - REM_W'(1);
    if (vsync_rise) begin
      line_d      = '0;
      in_vblank_d = 1'b0;
      remain_d    = '0;
    end else if (den_fall && !in_vblank_q) begin
      line_d = line_q + LINE_W'(1);
      if (line_q == LINE_LAST) begin
        in_vblank_d = 1'b1;
        remain_d    = REM_LOAD;
      end
    end
  end

  // Ownership FSM; cnt_q restarts on every state change and times guards and release.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    armed_d     = armed_q | ~req_s;
    ovr_flag_d  = ovr_flag_q;
    ovr_pulse_d = 1'b0;
    gcnt_d      = gcnt_q;
    if (vsync_rise && (state_q == MCU_OWN || state_q == RECLAIM_WAIT ||
                       state_q == RECLAIM_GUARD)) begin
      ovr_flag_d = 1'b1;
    end
    case (state_q)
      LCD_OWN: begin
        if (req_s && armed_q && in_vblank_q && remain_q >= MIN_WIN_R) state_d = REL_WAIT;
      end
      REL_WAIT: begin
        if (remain_q < REVOKE_R)  state_d = LCD_OWN;
        else if (!psram_busy)     state_d = REL_GUARD;
      end
      REL_GUARD: begin
        if (cnt_q == TURN_LAST) begin
          state_d    = MCU_OWN;
          ovr_flag_d = 1'b0;
        end
      end
      MCU_OWN: begin
        if (!req_s || remain_q <= REVOKE_R || vsync_rise) state_d = RECLAIM_WAIT;
      end
      RECLAIM_WAIT: begin
        if (!req_s || cnt_q == TO_LAST) state_d = RECLAIM_GUARD;
      end
      RECLAIM_GUARD: begin
        if (cnt_q == TURN_LAST) begin
          state_d     = LCD_OWN;
          gcnt_d      = gcnt_q + 8'd1;
          ovr_pulse_d = ovr_flag_q | vsync_rise;
          // A request still high here must drop before it can win again.
          armed_d     = 1'b0;
        end
      end
      default: state_d = LCD_OWN;
    endcase
    if (state_d != state_q) cnt_d = '0;
    ctrl_d = (state_d == LCD_OWN) || (state_d == REL_WAIT);
    ack_d  = (state_d == MCU_OWN);
    hold_d = (state_d != LCD_OWN);
  end

  always_ff @(posedge LCD_PCLK or posedge GLOBAL_RESET) begin
    if (GLOBAL_RESET) begin
      state_q     <= LCD_OWN;
      vsync_q     <= 1'b0;
      den_q       <= 1'b0;
      line_q      <= '0;
      in_vblank_q <= 1'b0;
      remain_q    <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b1;
      ovr_flag_q  <= 1'b0;
      ovr_pulse_q <= 1'b0;
      gcnt_q      <= '0;
      ctrl_q      <= 1'b1;
      ack_q       <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync_d;
      den_q       <= den_d;
      line_q      <= line_d;
      in_vblank_q <= in_vblank_d;
      remain_q    <= remain_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      ovr_flag_q  <= ovr_flag_d;
      ovr_pulse_q <= ovr_pulse_d;
      gcnt_q      <= gcnt_d;
      ctrl_q      <= ctrl_d;
      ack_q       <= ack_d;
      hold_q      <= hold_d;
    end
  end

  assign psram_ctrl    = ctrl_q;
  assign mcu_ack       = ack_q;
  assign lcd_hold      = hold_q;
  assign frame_overrun = ovr_pulse_q;
  assign grant_cnt     = gcnt_q;

endmodule
